// File: rtl/generic_bus_ram_responder_pkg.sv
// Shared types and constants for the generic bus RAM responder.
// Bus word geometry, FSM states and operation encoding.
package generic_bus_ram_responder_pkg;

  localparam int BUS_W = 32;
  localparam int LANES = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } resp_state_t;

  typedef enum logic [0:0] {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } bus_op_t;

endpackage

// File: rtl/generic_bus_if.sv
// Generic data bus between load/store unit and memory.
// master: initiator side; generic_bus: responder side.
interface generic_bus_if;
  import generic_bus_ram_responder_pkg::*;

  logic             ren;
  logic             wen;
  logic [BUS_W-1:0] addr;
  logic [BUS_W-1:0] wdata;
  logic [LANES-1:0] byte_en;
  logic [BUS_W-1:0] rdata;
  logic             busy;

  modport generic_bus (
    input  ren, wen, addr, wdata, byte_en,
    output rdata, busy
  );

  modport master (
    output ren, wen, addr, wdata, byte_en,
    input  rdata, busy
  );

endinterface

// File: rtl/generic_bus_ram_responder_ram.sv
// byte_write_ram: DEPTH_WORDS x 32 single-port array, per-lane
// write enables, registered read (clk, re, we, addr, wdata -> rdata).
module byte_write_ram
  import generic_bus_ram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              re,
  input  logic [LANES-1:0]  we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BUS_W-1:0]  wdata,
  output logic [BUS_W-1:0]  rdata
);

  logic [BUS_W-1:0] mem [DEPTH_WORDS];
  logic [BUS_W-1:0] rdata_q;

  // No reset so the array and its output register map to block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/generic_bus_ram_responder.sv
// RAM responder on the generic bus: latches a request, waits LATENCY
// cycles, then completes with a one-cycle busy-low pulse. Ports: CLK, RST, bus.
module generic_bus_ram_responder
  import generic_bus_ram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic CLK,
  input  logic RST,
  generic_bus_if.generic_bus bus
);

  resp_state_t       state_q, state_d;
  bus_op_t           op_q, op_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [BUS_W-1:0]  wdata_q, wdata_d;
  logic [LANES-1:0]  be_q, be_d;
  logic [BUS_W-1:0]  rdata_q, rdata_d;

  logic              active;
  logic              accept;
  logic              done;
  logic              rd_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re;
  logic [LANES-1:0]  ram_we;
  logic [BUS_W-1:0]  ram_rdata;
  logic [ADDR_W-1:0] req_idx;
  logic              unused_addr;

  assign req_idx = bus.addr[ADDR_W+1:2];
  assign unused_addr = ^{bus.addr[BUS_W-1:ADDR_W+2], bus.addr[1:0]};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    accept  = 1'b0;
    done    = 1'b0;
    active  = (op_q == OP_WRITE) ? bus.wen : bus.ren;
    unique case (state_q)
      IDLE: begin
        if (bus.ren || bus.wen) begin
          accept  = 1'b1;
          idx_d   = req_idx;
          wdata_d = bus.wdata;
          be_d    = bus.byte_en;
          op_d    = bus.wen ? OP_WRITE : OP_READ;
          cnt_d   = 4'(LATENCY);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!active) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Array address follows the live bus while idle so a read can
  // launch on the acceptance edge; afterwards the latched index.
  always_comb begin
    ram_addr = (state_q == IDLE) ? req_idx : idx_q;
    ram_re   = accept && !bus.wen;
    ram_we   = (done && op_q == OP_WRITE) ? be_q : '0;
    rd_done  = done && (op_q == OP_READ);
    rdata_d  = rd_done ? ram_rdata : rdata_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  byte_write_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk   (CLK),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // The array output register is already stable for the whole
  // completion cycle; rdata_q keeps it afterwards.
  assign bus.busy  = !done;
  assign bus.rdata = rd_done ? ram_rdata : rdata_q;

endmodule

// File: tb/tb_generic_bus_ram_responder.sv
// Bench for generic_bus_ram_responder: three instances at LATENCY 2, 4, 0
// driven by directed and random transactions against a word-array model.
module tb_generic_bus_ram_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [2:0]  ren = '0;
  logic [2:0]  wen = '0;
  logic [2:0]  busy;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [3:0]  be    [3];

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mem [3][1024];
  logic [31:0] last_rd [3];

  always #5 CLK = ~CLK;

  generic_bus_if bif0 ();
  generic_bus_if bif1 ();
  generic_bus_if bif2 ();

  assign bif0.ren = ren[0];
  assign bif0.wen = wen[0];
  assign bif0.addr = addr[0];
  assign bif0.wdata = wdata[0];
  assign bif0.byte_en = be[0];
  assign busy[0] = bif0.busy;
  assign rdata[0] = bif0.rdata;

  assign bif1.ren = ren[1];
  assign bif1.wen = wen[1];
  assign bif1.addr = addr[1];
  assign bif1.wdata = wdata[1];
  assign bif1.byte_en = be[1];
  assign busy[1] = bif1.busy;
  assign rdata[1] = bif1.rdata;

  assign bif2.ren = ren[2];
  assign bif2.wen = wen[2];
  assign bif2.addr = addr[2];
  assign bif2.wdata = wdata[2];
  assign bif2.byte_en = be[2];
  assign busy[2] = bif2.busy;
  assign rdata[2] = bif2.rdata;

  generic_bus_ram_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut0 (
    .CLK (CLK), .RST (RST), .bus (bif0)
  );
  generic_bus_ram_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut1 (
    .CLK (CLK), .RST (RST), .bus (bif1)
  );
  generic_bus_ram_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut2 (
    .CLK (CLK), .RST (RST), .bus (bif2)
  );

  function automatic int lat_of(input int d);
    case (d)
      0: return 2;
      1: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Called at a falling edge with the responder idle.
  task automatic txn(input int d, input bit wr, input bit rd,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, input string tag);
    int n;
    logic [9:0] ix;
    ren[d] = rd;
    wen[d] = wr;
    addr[d] = a;
    wdata[d] = wd;
    be[d] = b;
    @(posedge CLK);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (busy[d]) begin
        addr[d] = $urandom;
        wdata[d] = $urandom;
        be[d] = 4'($urandom);
      end
    end while (busy[d] && n < 40);
    chk({tag, "_lat"}, 32'(n), 32'(lat_of(d) + 1));
    ix = a[11:2];
    if (wr) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) mem[d][ix][8*i +: 8] = wd[8*i +: 8];
      chk({tag, "_hold"}, rdata[d], last_rd[d]);
    end else begin
      chk({tag, "_rd"}, rdata[d], mem[d][ix]);
      last_rd[d] = mem[d][ix];
    end
    @(negedge CLK);
    ren[d] = 1'b0;
    wen[d] = 1'b0;
    chk({tag, "_gap"}, 32'(busy[d]), 32'd1);
  endtask

  task automatic abort_txn(input int d, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] b,
                           input int k, input string tag);
    bit seen;
    ren[d] = !wr;
    wen[d] = wr;
    addr[d] = a;
    wdata[d] = wd;
    be[d] = b;
    @(posedge CLK);
    seen = 1'b0;
    repeat (k) begin
      @(negedge CLK);
      if (!busy[d]) seen = 1'b1;
    end
    ren[d] = 1'b0;
    wen[d] = 1'b0;
    repeat (lat_of(d) + 3) begin
      @(negedge CLK);
      if (!busy[d]) seen = 1'b1;
    end
    chk({tag, "_nodone"}, 32'(seen), 32'd0);
    chk({tag, "_hold"}, rdata[d], last_rd[d]);
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    logic [31:0] ix;
    r = $urandom_range(0, 16);
    ix = (r == 16) ? 32'd1023 : 32'(r);
    return ($urandom & 32'hFFFF_F000) | (ix << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    for (int d = 0; d < 3; d++) begin
      addr[d] = '0;
      wdata[d] = '0;
      be[d] = '0;
      last_rd[d] = '0;
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd1);
      chk($sformatf("rst_rdata%0d", d), rdata[d], 32'd0);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 17; w++) begin
        logic [31:0] ia;
        ia = (w == 16) ? 32'h0000_0FFC : 32'(w) << 2;
        txn(d, 1'b1, 1'b0, ia, $urandom, 4'hF, "init");
      end
    end

    txn(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, "t1w");
    txn(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, "t1r");
    chk("t1_const", rdata[0], 32'hDEADBEEF);

    txn(0, 1'b1, 1'b0, 32'h10, 32'h55555555, 4'b0100, "t2w");
    txn(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, "t2r");
    chk("t2_const", rdata[0], 32'hDE55BEEF);
    txn(0, 1'b1, 1'b0, 32'h10, 32'hFFFFFFFF, 4'h0, "t2w0");
    txn(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, "t2r0");
    chk("t2_be0", rdata[0], 32'hDE55BEEF);

    txn(0, 1'b1, 1'b0, 32'h0000_1000, 32'h12345678, 4'hF, "t3w");
    txn(0, 1'b0, 1'b1, 32'h0000_0002, 32'h0, 4'h0, "t3r");
    chk("t3_alias", rdata[0], 32'h12345678);
    txn(0, 1'b0, 1'b1, 32'h0000_0FFC, 32'h0, 4'h0, "t3top");

    abort_txn(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 2, "t4");
    txn(1, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0, "t4r");

    txn(0, 1'b1, 1'b1, 32'h30, 32'h0000_00AA, 4'hF, "t5w");
    txn(0, 1'b0, 1'b1, 32'h30, 32'h0, 4'h0, "t5r");
    chk("t5_const", rdata[0], 32'h0000_00AA);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] ba;
      ba = 32'((i / 2) * 4 + 32'h40);
      if (i % 2 == 0) txn(2, 1'b1, 1'b0, ba, $urandom, 4'hF, "t6w");
      else txn(2, 1'b0, 1'b1, ba, 32'h0, 4'h0, "t6r");
    end

    ren[0] = 1'b0;
    wen[0] = 1'b1;
    addr[0] = 32'h10;
    wdata[0] = 32'h0BADF00D;
    be[0] = 4'hF;
    @(posedge CLK);
    @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy[0]), 32'd1);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_mid_rdata%0d", d), rdata[d], 32'd0);
      last_rd[d] = '0;
    end
    wen[0] = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    txn(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, "rst_rd");

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 40; i++) begin
        int c;
        c = $urandom_range(0, 9);
        if (c == 0 && lat_of(d) > 0)
          abort_txn(d, 1'($urandom), rnd_addr(), $urandom, 4'($urandom),
                    $urandom_range(1, lat_of(d)), "rnd_ab");
        else if (c <= 4)
          txn(d, 1'b1, 1'b0, rnd_addr(), $urandom, 4'($urandom), "rnd_w");
        else if (c <= 8)
          txn(d, 1'b0, 1'b1, rnd_addr(), 32'h0, 4'h0, "rnd_r");
        else
          txn(d, 1'b1, 1'b1, rnd_addr(), $urandom, 4'($urandom), "rnd_wr");
      end
      for (int w = 0; w < 17; w++) begin
        logic [31:0] ia;
        ia = (w == 16) ? 32'h0000_0FFC : 32'(w) << 2;
        txn(d, 1'b0, 1'b1, ia, 32'h0, 4'h0, "final");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
